zapper_hit_detect: RTL

- Receiving end of the light-gun flash sequence.
- Debounces the gun trigger and raises flash_req, which drives the pattern generator's trigger input.
- Tracks that generator frame by frame (armed, black frame, white-box frame).
- Integrates the photodiode over the black and white frames, then emits one hit or miss pulse per shot plus a saturating hit counter.

---
 rtl/zapper_pkg.sv | 25 ++
 rtl/zapper_hit_detect_trigger_debounce.sv | 65 ++++++
 rtl/zapper_hit_detect.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/zapper_pkg.sv
// Shared types and default constants for the light-gun hit detector.
package zapper_pkg;

    // Shot sequencing states, one per generator frame plus bookkeeping.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        DARK   = 3'd2,
        BRIGHT = 3'd3,
        REPORT = 3'd4,
        HOLD   = 3'd5
    } zapper_state_t;

    localparam int ZAP_SYNC_STAGES     = 2;
    localparam int ZAP_DEBOUNCE_CYCLES = 250000;
    localparam int ZAP_CNT_W           = 16;
    localparam int ZAP_DARK_MAX        = 16;
    localparam int ZAP_LIGHT_MIN       = 64;

    // Increment an 8-bit value, sticking at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/zapper_hit_detect_trigger_debounce.sv
// Synchroniser plus level debouncer for the gun trigger. The debounced
// level only follows the synchronised input after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles; rise pulses for one cycle, aligned
// with the cycle in which the new high level first appears.
module trigger_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("trigger_debounce: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("trigger_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_s;
    logic [DB_W-1:0]        db_cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;

    assign sync_s = sync_reg[SYNC_STAGES-1];
    assign level  = level_reg;
    assign rise   = rise_reg;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            rise_reg   <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            if (sync_s == level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                db_cnt_reg <= '0;
                level_reg  <= sync_s;
                rise_reg   <= sync_s;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zapper_hit_detect.sv
// Receiving end of the light-gun flash sequence: debounces the trigger,
// requests a flash, follows the generator through its black and white
// frames while integrating the photodiode, then scores the shot.
module zapper_hit_detect
    import zapper_pkg::*;
#(
    parameter int SYNC_STAGES     = ZAP_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = ZAP_DEBOUNCE_CYCLES,
    parameter int CNT_W           = ZAP_CNT_W,
    parameter int DARK_MAX        = ZAP_DARK_MAX,
    parameter int LIGHT_MIN       = ZAP_LIGHT_MIN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic       light,
    input  logic       frame_tick,
    output logic       flash_req,
    output logic       hit,
    output logic       miss,
    output logic [7:0] hit_count
);

    // Thresholds must be representable in the counter width, otherwise the
    // unsigned compares below would silently truncate them.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("zapper_hit_detect: SYNC_STAGES must be at least 2");
    end
    if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
        $error("zapper_hit_detect: CNT_W out of range");
    end
    if (DARK_MAX < 0 || 64'(DARK_MAX) >= (64'd1 << CNT_W)) begin : g_bad_dark
        $error("zapper_hit_detect: DARK_MAX must be below 2**CNT_W");
    end
    if (LIGHT_MIN < 0 || 64'(LIGHT_MIN) >= (64'd1 << CNT_W)) begin : g_bad_light
        $error("zapper_hit_detect: LIGHT_MIN must be below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] DARK_MAX_C  = CNT_W'(DARK_MAX);
    localparam logic [CNT_W-1:0] LIGHT_MIN_C = CNT_W'(LIGHT_MIN);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

    logic                   trigger_db;
    logic                   press;
    logic [SYNC_STAGES-1:0] light_sync_reg;
    logic                   light_s;

    zapper_state_t          state_reg;
    zapper_state_t          state_next;
    logic                   dark_clr;
    logic                   light_clr;
    logic                   shot_pass;
    logic [CNT_W-1:0]       dark_cnt_reg;
    logic [CNT_W-1:0]       light_cnt_reg;
    logic                   flash_req_reg;
    logic [7:0]             hit_count_reg;

    trigger_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_trigger_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(trigger),
        .level   (trigger_db),
        .rise    (press)
    );

    assign light_s   = light_sync_reg[SYNC_STAGES-1];
    assign flash_req = flash_req_reg;
    assign hit_count = hit_count_reg;
    assign shot_pass = (dark_cnt_reg <= DARK_MAX_C) && (light_cnt_reg >= LIGHT_MIN_C);

    // Bring the photodiode comparator into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            light_sync_reg <= '0;
        end else begin
            light_sync_reg <= {light_sync_reg[SYNC_STAGES-2:0], light};
        end
    end

    // State register plus flash request, registered from the next state so
    // it drops in the same cycle IDLE is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            flash_req_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flash_req_reg <= (state_next != IDLE);
        end
    end

    // Next-state, counter clears and the one-cycle result pulses.
    always_comb begin
        state_next = state_reg;
        dark_clr   = 1'b0;
        light_clr  = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        case (state_reg)
            IDLE: begin
                // A frame_tick coinciding with the press is deliberately
                // not seen: ARM waits for the following boundary.
                if (press) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (frame_tick) begin
                    state_next = DARK;
                    dark_clr   = 1'b1;
                end
            end
            DARK: begin
                if (frame_tick) begin
                    state_next = BRIGHT;
                    light_clr  = 1'b1;
                end
            end
            BRIGHT: begin
                if (frame_tick) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                hit        = shot_pass;
                miss       = !shot_pass;
                state_next = HOLD;
            end
            HOLD: begin
                if (!trigger_db) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Integrate light-high cycles over the black and white frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dark_cnt_reg  <= '0;
            light_cnt_reg <= '0;
        end else begin
            if (dark_clr) begin
                dark_cnt_reg <= '0;
            end else if (state_reg == DARK && light_s && dark_cnt_reg != CNT_SAT) begin
                dark_cnt_reg <= dark_cnt_reg + 1'b1;
            end
            if (light_clr) begin
                light_cnt_reg <= '0;
            end else if (state_reg == BRIGHT && light_s && light_cnt_reg != CNT_SAT) begin
                light_cnt_reg <= light_cnt_reg + 1'b1;
            end
        end
    end

    // Saturating tally of scored shots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_reg <= 8'd0;
        end else if (hit) begin
            hit_count_reg <= sat_inc8(hit_count_reg);
        end
    end

endmodule
